// File: rtl/car_sensor_driver.sv
// car_sensor_driver
//   Drives the outer (a) and inner (b) sensor lines of a parking-lot gate
//   model. Each accepted command plays a fixed sensor pattern, ends with a
//   quiet gap, and updates the modelled car count when it completes.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   cmd        01 enter, 10 exit, 11 pedestrian, 00 none
//   cmd_valid  cmd is offered this cycle
//   cmd_ready  block can take a command this cycle (idle, no abort)
//   abort      cuts the running sensor pattern short and jumps to the gap
//   a, b       registered outer / inner sensor drive
//   busy       high whenever a sequence is running
//   done       one-cycle pulse on normal completion
//   reject     one-cycle pulse when an enter/exit is refused
//   occupancy  modelled car count, saturating at 0 and CAPACITY
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a command; a=b=0
// P1    | first sensor pattern, PHASE_CYCLES long
// P2    | second sensor pattern, PHASE_CYCLES long
// P3    | third sensor pattern (enter/exit only), PHASE_CYCLES long
// GAP   | a=b=0 for GAP_CYCLES, then back to IDLE
module car_sensor_driver #(
  parameter int PHASE_CYCLES = 1,
  parameter int GAP_CYCLES   = 2,
  parameter int CAPACITY     = 5,
  localparam int OCC_W       = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       cmd,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             abort,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             reject,
  output logic [OCC_W-1:0] occupancy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_P3   = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  localparam logic [1:0] CMD_ENTER = 2'b01;
  localparam logic [1:0] CMD_EXIT  = 2'b10;
  localparam logic [1:0] CMD_PED   = 2'b11;

  // Counters are loaded with length-1 and expire at zero.
  localparam logic [7:0]       PH_LOAD  = 8'(PHASE_CYCLES - 1);
  localparam logic [7:0]       GAP_LOAD = 8'(GAP_CYCLES - 1);
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(CAPACITY);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       kind_q, kind_d;
  logic             aborted_q, aborted_d;
  logic             a_d, b_d, done_d, reject_d;
  logic [OCC_W-1:0] occ_d;
  logic             full, empty;

  // Sensor pattern {a,b} shown while in a given state for a given command.
  function automatic logic [1:0] drive_pattern(input logic [1:0] kind, input state_t st);
    logic [1:0] p;
    p = 2'b00;
    case (st)
      S_P1:    p = (kind == CMD_EXIT) ? 2'b01 : 2'b10;
      S_P2:    p = (kind == CMD_PED)  ? 2'b01 : 2'b11;
      S_P3:    p = (kind == CMD_EXIT) ? 2'b10 : 2'b01;
      default: p = 2'b00;
    endcase
    return p;
  endfunction

  assign cmd_ready = (state_q == S_IDLE) && !abort;
  assign busy      = (state_q != S_IDLE);
  assign full      = (occupancy == OCC_MAX);
  assign empty     = (occupancy == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      kind_q    <= 2'b00;
      aborted_q <= 1'b0;
      a         <= 1'b0;
      b         <= 1'b0;
      done      <= 1'b0;
      reject    <= 1'b0;
      occupancy <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      kind_q    <= kind_d;
      aborted_q <= aborted_d;
      a         <= a_d;
      b         <= b_d;
      done      <= done_d;
      reject    <= reject_d;
      occupancy <= occ_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kind_d    = kind_q;
    aborted_d = aborted_q;
    occ_d     = occupancy;
    done_d    = 1'b0;
    reject_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready && (cmd != 2'b00)) begin
          // Refused commands never leave IDLE, so the count cannot wrap.
          if ((cmd == CMD_ENTER && full) || (cmd == CMD_EXIT && empty)) begin
            reject_d = 1'b1;
          end else begin
            state_d   = S_P1;
            kind_d    = cmd;
            aborted_d = 1'b0;
            cnt_d     = PH_LOAD;
          end
        end
      end
      S_P1, S_P2, S_P3: begin
        if (abort) begin
          state_d   = S_GAP;
          cnt_d     = GAP_LOAD;
          aborted_d = 1'b1;
        end else if (cnt_q == 8'd0) begin
          cnt_d = PH_LOAD;
          case (state_q)
            S_P1: state_d = S_P2;
            S_P2: begin
              if (kind_q == CMD_PED) begin
                state_d = S_GAP;
                cnt_d   = GAP_LOAD;
              end else begin
                state_d = S_P3;
              end
            end
            default: begin
              state_d = S_GAP;
              cnt_d   = GAP_LOAD;
            end
          endcase
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_GAP: begin
        // abort is deliberately ignored here: the gap always runs in full.
        if (cnt_q == 8'd0) begin
          state_d = S_IDLE;
          if (!aborted_q) begin
            done_d = 1'b1;
            if (kind_q == CMD_ENTER)     occ_d = occupancy + OCC_W'(1);
            else if (kind_q == CMD_EXIT) occ_d = occupancy - OCC_W'(1);
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    {a_d, b_d} = drive_pattern(kind_d, state_d);
  end

endmodule

// File: tb/tb_car_sensor_driver.sv
// Bench for car_sensor_driver: two instances (default timing and
// PHASE_CYCLES=3) share one stimulus stream. A schedule-queue model predicts
// every output each cycle; directed scenarios add literal expectations.
module tb_car_sensor_driver;

  localparam int GAPC = 2;
  localparam int CAP  = 5;

  logic       clk, reset, cmd_valid, abort;
  logic [1:0] cmd;
  logic       rdy_o[2], a_o[2], b_o[2], busy_o[2], done_o[2], rej_o[2];
  logic [2:0] occ_o[2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  car_sensor_driver #(.PHASE_CYCLES(1), .GAP_CYCLES(GAPC), .CAPACITY(CAP)) dut0 (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(rdy_o[0]),
    .abort(abort), .a(a_o[0]), .b(b_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .reject(rej_o[0]), .occupancy(occ_o[0]));

  car_sensor_driver #(.PHASE_CYCLES(3), .GAP_CYCLES(GAPC), .CAPACITY(CAP)) dut1 (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(rdy_o[1]),
    .abort(abort), .a(a_o[1]), .b(b_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .reject(rej_o[1]), .occupancy(occ_o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each accepted command expands into a list of per-cycle entries
  // {in_phase, a, b}; the model pops one entry per cycle.
  logic [2:0] plan[2][$];
  bit         busy_m[2], cur_phase[2], aborted_m[2], done_m[2], rej_m[2];
  logic [1:0] ab_m[2];
  int         occ_m[2], delta_m[2];

  function automatic int phase_len(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic model_clear(input int k);
    plan[k].delete();
    busy_m[k] = 0; cur_phase[k] = 0; aborted_m[k] = 0;
    done_m[k] = 0; rej_m[k] = 0; ab_m[k] = 2'b00; occ_m[k] = 0; delta_m[k] = 0;
  endtask

  task automatic model_step(input int k);
    logic [2:0] e;
    logic [1:0] pats[3];
    int np;
    done_m[k] = 0;
    rej_m[k]  = 0;
    if (busy_m[k]) begin
      if (plan[k].size() == 0) begin
        busy_m[k] = 0;
        ab_m[k]   = 2'b00;
        if (!aborted_m[k]) begin
          done_m[k] = 1;
          occ_m[k] += delta_m[k];
        end
      end else begin
        if (abort && cur_phase[k]) begin
          plan[k].delete();
          for (int i = 0; i < GAPC; i++) plan[k].push_back(3'b000);
          aborted_m[k] = 1;
        end
        e = plan[k].pop_front();
        ab_m[k] = e[1:0];
        cur_phase[k] = e[2];
      end
    end else begin
      ab_m[k] = 2'b00;
      if (cmd_valid && !abort && cmd != 2'b00) begin
        if ((cmd == 2'b01 && occ_m[k] == CAP) || (cmd == 2'b10 && occ_m[k] == 0)) begin
          rej_m[k] = 1;
        end else begin
          case (cmd)
            2'b01:   begin pats = '{2'b10, 2'b11, 2'b01}; np = 3; delta_m[k] = 1;  end
            2'b10:   begin pats = '{2'b01, 2'b11, 2'b10}; np = 3; delta_m[k] = -1; end
            default: begin pats = '{2'b10, 2'b01, 2'b00}; np = 2; delta_m[k] = 0;  end
          endcase
          aborted_m[k] = 0;
          plan[k].delete();
          for (int p = 0; p < np; p++)
            for (int i = 0; i < phase_len(k); i++) plan[k].push_back({1'b1, pats[p]});
          for (int i = 0; i < GAPC; i++) plan[k].push_back(3'b000);
          e = plan[k].pop_front();
          ab_m[k] = e[1:0];
          cur_phase[k] = e[2];
          busy_m[k] = 1;
        end
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_clear(0);
      model_clear(1);
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("u%0d_ab", k), {a_o[k], b_o[k]}, ab_m[k]);
        check($sformatf("u%0d_busy", k), busy_o[k], busy_m[k]);
        check($sformatf("u%0d_done", k), done_o[k], done_m[k]);
        check($sformatf("u%0d_reject", k), rej_o[k], rej_m[k]);
        check($sformatf("u%0d_occ", k), occ_o[k], occ_m[k]);
        check($sformatf("u%0d_ready", k), rdy_o[k], (!busy_m[k] && !abort) ? 1 : 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_m[0] || busy_m[1]) && n < 100) begin
      tick();
      n++;
    end
    check("wait_idle_timeout", (busy_m[0] || busy_m[1]) ? 1 : 0, 0);
  endtask

  initial begin
    reset = 1'b1; cmd = 2'b00; cmd_valid = 1'b0; abort = 1'b0;
    #2 reset = 1'b0;
    #1 chk_en = 1;
    check("rst_a", a_o[0], 0);
    check("rst_b", b_o[0], 0);
    check("rst_busy", busy_o[0], 0);
    check("rst_done", done_o[0], 0);
    check("rst_reject", rej_o[0], 0);
    check("rst_occ", occ_o[0], 0);
    repeat (3) tick();
    reset = 1'b1;
    #1 check("ready_after_release", rdy_o[0], 1);
    tick();

    // Pedestrian from occupancy 0
    cmd = 2'b11; cmd_valid = 1'b1;
    tick(); cmd_valid = 1'b0;
    check("ped_c1_ab", {a_o[0], b_o[0]}, 2'b10);
    tick(); check("ped_c2_ab", {a_o[0], b_o[0]}, 2'b01);
    tick(); check("ped_c3_ab", {a_o[0], b_o[0]}, 2'b00);
    check("ped_c3_busy", busy_o[0], 1);
    tick(); check("ped_c4_ab", {a_o[0], b_o[0]}, 2'b00);
    tick(); check("ped_c5_done", done_o[0], 1);
    check("ped_c5_occ", occ_o[0], 0);
    wait_idle();

    // Enters held back-to-back up to capacity, then exits down to zero
    cmd = 2'b01; cmd_valid = 1'b1;
    for (int c = 1; c <= 62; c++) begin
      tick();
      case (c)
        1:  check("ent_c1_ab", {a_o[0], b_o[0]}, 2'b10);
        2:  check("ent_c2_ab", {a_o[0], b_o[0]}, 2'b11);
        3:  check("ent_c3_ab", {a_o[0], b_o[0]}, 2'b01);
        4:  begin check("ent_c4_ab", {a_o[0], b_o[0]}, 2'b00); check("ent_c4_busy", busy_o[0], 1); end
        5:  check("ent_c5_ab", {a_o[0], b_o[0]}, 2'b00);
        6:  begin check("ent_c6_done", done_o[0], 1); check("ent_c6_occ", occ_o[0], 1); end
        12: check("ent_c12_occ", occ_o[0], 2);
        30: begin check("full_c30_occ", occ_o[0], 5); check("full_c30_done", done_o[0], 1); end
        31: begin
          check("full_reject", rej_o[0], 1);
          check("full_ab", {a_o[0], b_o[0]}, 2'b00);
          check("full_busy", busy_o[0], 0);
          check("full_occ", occ_o[0], 5);
          cmd = 2'b10;
        end
        61: begin check("empty_c61_occ", occ_o[0], 0); check("empty_c61_done", done_o[0], 1); end
        62: begin check("empty_reject", rej_o[0], 1); check("empty_occ", occ_o[0], 0); end
        default: ;
      endcase
    end
    cmd_valid = 1'b0;
    wait_idle();

    // Steer the slow instance to occupancy 2, then abort its exit in P2
    for (int i = 0; i < 10 && occ_m[1] != 2; i++) begin
      cmd = (occ_m[1] < 2) ? 2'b01 : 2'b10;
      cmd_valid = 1'b1;
      tick(); cmd_valid = 1'b0;
      wait_idle();
    end
    check("abort_start_occ", occ_o[1], 2);
    cmd = 2'b10; cmd_valid = 1'b1;
    tick(); cmd_valid = 1'b0;
    check("abort_c1_ab", {a_o[1], b_o[1]}, 2'b01);
    tick(); tick(); tick();
    check("abort_c4_ab", {a_o[1], b_o[1]}, 2'b11);
    tick(); abort = 1'b1;
    tick(); abort = 1'b0;
    check("abort_c6_ab", {a_o[1], b_o[1]}, 2'b00);
    check("abort_c6_busy", busy_o[1], 1);
    tick(); check("abort_c7_busy", busy_o[1], 1);
    tick(); check("abort_c8_busy", busy_o[1], 0);
    check("abort_c8_done", done_o[1], 0);
    check("abort_c8_occ", occ_o[1], 2);
    wait_idle();

    // Asynchronous reset in the middle of an enter
    cmd = 2'b01; cmd_valid = 1'b1;
    tick(); cmd_valid = 1'b0;
    tick(); check("rmid_c2_ab", {a_o[0], b_o[0]}, 2'b11);
    #2 reset = 1'b0;
    #1;
    check("rmid_ab", {a_o[0], b_o[0]}, 2'b00);
    check("rmid_busy", busy_o[0], 0);
    check("rmid_occ", occ_o[0], 0);
    check("rmid_busy_u1", busy_o[1], 0);
    tick(); tick();
    reset = 1'b1;
    #0 check("rmid_ready", rdy_o[0], 1);
    cmd = 2'b01; cmd_valid = 1'b1;
    tick(); cmd_valid = 1'b0;
    repeat (5) tick();
    check("rmid_enter_done", done_o[0], 1);
    check("rmid_enter_occ", occ_o[0], 1);
    wait_idle();

    // Enter held while an exit is running
    cmd = 2'b10; cmd_valid = 1'b1;
    tick(); cmd = 2'b01;
    for (int c = 1; c < 6; c++) begin
      check("hold_no_reject", rej_o[0], 0);
      check("hold_busy", busy_o[0], 1);
      tick();
    end
    check("hold_exit_done", done_o[0], 1);
    check("hold_exit_occ", occ_o[0], 0);
    tick();
    cmd_valid = 1'b0;
    check("hold_enter_ab", {a_o[0], b_o[0]}, 2'b10);
    check("hold_enter_rej", rej_o[0], 0);
    repeat (5) tick();
    check("hold_enter_done", done_o[0], 1);
    check("hold_enter_occ", occ_o[0], 1);
    wait_idle();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cmd       = 2'($urandom_range(0, 3));
      cmd_valid = ($urandom_range(0, 3) != 0);
      abort     = ($urandom_range(0, 19) == 0);
      tick();
    end
    cmd_valid = 1'b0; abort = 1'b0;
    wait_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/car_sensor_driver.md
CAR_SENSOR_DRIVER -- requirements
Module: car_sensor_driver

Interface
REQ-001 SHALL have parameter PHASE_CYCLES, default 1: cycles each non-idle sensor phase is held (legal 1..255).
REQ-002 SHALL have parameter GAP_CYCLES, default 2: cycles of a=0,b=0 after each sequence (legal 1..255).
REQ-003 SHALL have parameter CAPACITY, default 5: maximum cars modelled in the lot (legal 1..99).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: one clock; reset is asynchronous and active-low (asserted when 0).
REQ-006 SHALL have port cmd, input, 2: 01 enter, 10 exit, 11 pedestrian, 00 none.
REQ-007 SHALL have port cmd_valid, input, 1: cmd is offered this cycle.
REQ-008 SHALL have port cmd_ready, output, 1: high only in IDLE with abort low.
REQ-009 SHALL have port abort, input, 1: synchronous abort of the sequence in progress.
REQ-010 SHALL have port a, output, 1: outer sensor drive, registered.
REQ-011 SHALL have port b, output, 1: inner sensor drive, registered.
REQ-012 SHALL have port busy, output, 1: high in every non-IDLE state.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when a sequence completes.
REQ-014 SHALL have port reject, output, 1: one-cycle pulse when a command is refused.
REQ-015 SHALL have port occupancy, output, $clog2(CAPACITY+1): modelled car count.

Function
REQ-016 SHALL accept a command on a rising edge where cmd_valid=1, cmd_ready=1 and cmd!=00; cmd=00 with cmd_valid=1 SHALL be ignored with no pulse.
REQ-017 SHALL use states IDLE, P1, P2, P3, GAP; an accepted legal command moves IDLE->P1 and a,b show the P1 pattern in the next cycle.
REQ-018 Enter SHALL drive (a,b) = 10 (P1), 11 (P2), 01 (P3), 00 (GAP).
REQ-019 Exit SHALL drive (a,b) = 01 (P1), 11 (P2), 10 (P3), 00 (GAP).
REQ-020 Pedestrian SHALL drive (a,b) = 10 (P1), 01 (P2), 00 (GAP), skipping P3.
REQ-021 Each of P1/P2/P3 SHALL last exactly PHASE_CYCLES cycles; GAP SHALL last exactly GAP_CYCLES cycles; phase counter 8 bits, reloaded on each state entry.
REQ-022 On GAP expiry the block SHALL enter IDLE, pulse done for one cycle (the first IDLE cycle), and update occupancy in that same cycle.
REQ-023 Occupancy SHALL increment by 1 on enter completion and decrement by 1 on exit completion; pedestrian SHALL leave it unchanged.
REQ-024 Enter accepted while occupancy==CAPACITY, or exit accepted while occupancy==0, SHALL pulse reject in the next cycle, stay IDLE, keep a=b=0, and leave occupancy unchanged; occupancy SHALL never wrap.
REQ-025 cmd_ready SHALL be low while busy, so a command offered while busy SHALL be neither accepted nor rejected; the requester holds it.
REQ-026 abort=1 in P1/P2/P3 SHALL force a=b=0 from the next cycle and go to GAP; completion SHALL return to IDLE with no done pulse and no occupancy change.
REQ-027 abort in GAP SHALL not shorten GAP; abort in IDLE SHALL block acceptance that cycle.
REQ-028 Back-to-back commands SHALL be accepted earliest in the done cycle, giving minimum GAP_CYCLES idle cycles between sequences.

Reset
REQ-029 While reset=0: state IDLE, a=0, b=0, busy=0, done=0, reject=0, occupancy=0, phase counter 0, regardless of clk.
REQ-030 Reset assertion mid-sequence SHALL drop a,b to 0 immediately without a done pulse; cmd_ready SHALL be high in the first clock cycle after release.

Verification
REQ-031 Defaults, enter accepted at cycle 0 -> (a,b)=10,11,01 at cycles 1,2,3; 00 at cycles 4-5; done=1 and occupancy=1 at cycle 6.
REQ-032 Pedestrian from occupancy 0 -> (a,b)=10,01,00,00 over cycles 1-4; done at cycle 5; occupancy stays 0.
REQ-033 Five enters back-to-back -> occupancy 5; sixth enter -> reject pulse one cycle later, a=b=0, occupancy 5; then five exits -> occupancy 0; an extra exit -> reject.
REQ-034 PHASE_CYCLES=3, exit from occupancy 2, abort during P2 -> a=b=0 next cycle, 2 GAP cycles, no done, occupancy 2.
REQ-035 Reset low during P2 of an enter -> a=b=0, busy=0, occupancy=0 asynchronously; an enter after release completes normally with occupancy 1.
REQ-036 cmd_valid held with cmd=01 throughout a busy exit -> no accept or reject until done cycle; enter accepted then, occupancy correct after both.
